// File: rtl/johnson_pkg.sv
// Shared types and code table for receivers of the 4-bit Johnson count stream.
package johnson_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b1000;
  localparam logic [3:0] CODE_2 = 4'b1100;
  localparam logic [3:0] CODE_3 = 4'b1110;
  localparam logic [3:0] CODE_4 = 4'b1111;
  localparam logic [3:0] CODE_5 = 4'b0111;
  localparam logic [3:0] CODE_6 = 4'b0011;
  localparam logic [3:0] CODE_7 = 4'b0001;

  // Returns {legal, count[2:0]}; illegal words map to {0, 000}.
  function automatic logic [3:0] johnson_lookup(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      CODE_0:  res = 4'b1_000;
      CODE_1:  res = 4'b1_001;
      CODE_2:  res = 4'b1_010;
      CODE_3:  res = 4'b1_011;
      CODE_4:  res = 4'b1_100;
      CODE_5:  res = 4'b1_101;
      CODE_6:  res = 4'b1_110;
      CODE_7:  res = 4'b1_111;
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code word decoder: legal flag plus binary count.
module johnson_code_decode
  import johnson_pkg::*;
(
  input  logic [3:0] code,
  output logic       legal,
  output logic [2:0] value
);

  logic [3:0] lookup;

  assign lookup = johnson_lookup(code);
  assign legal  = lookup[3];
  assign value  = lookup[2:0];

endmodule

// File: rtl/johnson_decoder_checker.sv
// Decodes a sampled Johnson code stream, tracks sequence lock and tallies link errors.
module johnson_decoder_checker
  import johnson_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int ALLOW_HOLD = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iValid,
  input  logic [3:0]           iCode,
  output logic [2:0]           oCount,
  output logic                 oCountValid,
  output logic                 oCodeError,
  output logic                 oSeqError,
  output logic                 oLocked,
  output logic [ERR_CNT_W-1:0] oErrCount
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic       legal;
  logic [2:0] value;

  johnson_code_decode u_decode (
    .code  (iCode),
    .legal (legal),
    .value (value)
  );

  state_t                state_p1, state_nx;
  logic [2:0]            prev_p1, prev_nx;
  logic [2:0]            match_p1, match_nx;
  logic [2:0]            cerr_p1, cerr_nx;
  logic [ERR_CNT_W-1:0]  err_cnt_p1, err_cnt_nx;
  logic [2:0]            count_p1, count_nx;
  logic                  vld_p1, vld_nx;
  logic                  code_err_p1, code_err_nx;
  logic                  seq_err_p1, seq_err_nx;

  logic [2:0] succ;
  logic       correct;
  logic [3:0] match_inc;
  logic [3:0] cerr_inc;

  assign succ      = prev_p1 + 3'd1;
  assign correct   = legal && ((value == succ) || ((ALLOW_HOLD != 0) && (value == prev_p1)));
  assign match_inc = {1'b0, match_p1} + 4'd1;
  assign cerr_inc  = {1'b0, cerr_p1} + 4'd1;

  always_comb begin
    state_nx    = state_p1;
    prev_nx     = prev_p1;
    match_nx    = match_p1;
    cerr_nx     = cerr_p1;
    err_cnt_nx  = err_cnt_p1;
    count_nx    = count_p1;
    vld_nx      = 1'b0;
    code_err_nx = 1'b0;
    seq_err_nx  = 1'b0;
    if (iValid) begin
      if (legal) begin
        count_nx = value;
        vld_nx   = 1'b1;
      end else begin
        code_err_nx = 1'b1;
      end
      unique case (state_p1)
        SEARCH: begin
          if (legal) begin
            prev_nx  = value;
            match_nx = 3'd0;
            state_nx = VERIFY;
          end
        end
        VERIFY: begin
          if (!legal) begin
            state_nx = SEARCH;
          end else if (correct) begin
            prev_nx = value;
            if (match_inc >= LOCK_N) begin
              state_nx = LOCKED;
              match_nx = 3'd0;
              cerr_nx  = 3'd0;
            end else begin
              match_nx = match_inc[2:0];
            end
          end else begin
            prev_nx  = value;
            match_nx = 3'd0;
          end
        end
        LOCKED: begin
          if (correct) begin
            prev_nx = value;
            cerr_nx = 3'd0;
          end else begin
            // Legal-but-wrong resyncs to the received value; illegal flywheels forward.
            seq_err_nx = legal;
            prev_nx    = legal ? value : succ;
            err_cnt_nx = sat_inc(err_cnt_p1);
            if (cerr_inc >= ERR_N) begin
              state_nx = SEARCH;
              cerr_nx  = 3'd0;
              match_nx = 3'd0;
            end else begin
              cerr_nx = cerr_inc[2:0];
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_p1    <= SEARCH;
      prev_p1     <= 3'd0;
      match_p1    <= 3'd0;
      cerr_p1     <= 3'd0;
      err_cnt_p1  <= '0;
      count_p1    <= 3'd0;
      vld_p1      <= 1'b0;
      code_err_p1 <= 1'b0;
      seq_err_p1  <= 1'b0;
    end else begin
      state_p1    <= state_nx;
      prev_p1     <= prev_nx;
      match_p1    <= match_nx;
      cerr_p1     <= cerr_nx;
      err_cnt_p1  <= err_cnt_nx;
      count_p1    <= count_nx;
      vld_p1      <= vld_nx;
      code_err_p1 <= code_err_nx;
      seq_err_p1  <= seq_err_nx;
    end
  end

  assign oCount      = count_p1;
  assign oCountValid = vld_p1;
  assign oCodeError  = code_err_p1;
  assign oSeqError   = seq_err_p1;
  assign oLocked     = (state_p1 == LOCKED);
  assign oErrCount   = err_cnt_p1;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench: two decoder instances (hold off / hold on with narrow tally) against a behavioural model.
module tb_johnson_decoder_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [3:0] code = 4'b0000;

  logic [2:0] cnt0, cnt1;
  logic       cv0, cv1, ce0, ce1, se0, se1, lk0, lk1;
  logic [7:0] ec0;
  logic [1:0] ec1;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  johnson_decoder_checker #(.LOCK_COUNT(3), .ERR_LIMIT(2), .ALLOW_HOLD(0), .ERR_CNT_W(8)) u0 (
    .iClk(clk), .iReset(rst), .iValid(vld), .iCode(code),
    .oCount(cnt0), .oCountValid(cv0), .oCodeError(ce0), .oSeqError(se0),
    .oLocked(lk0), .oErrCount(ec0)
  );

  johnson_decoder_checker #(.LOCK_COUNT(3), .ERR_LIMIT(2), .ALLOW_HOLD(1), .ERR_CNT_W(2)) u1 (
    .iClk(clk), .iReset(rst), .iValid(vld), .iCode(code),
    .oCount(cnt1), .oCountValid(cv1), .oCodeError(ce1), .oSeqError(se1),
    .oLocked(lk1), .oErrCount(ec1)
  );

  // Behavioural model: mode 0 = hunting, 1 = confirming, 2 = locked
  int m_mode[2], m_prev[2], m_run[2], m_bad[2], m_tally[2];
  int m_count[2], m_cv[2], m_ce[2], m_se[2];
  int m_hold[2]  = '{0, 1};
  int m_tmax[2]  = '{255, 3};

  function automatic int decode(input logic [3:0] c);
    logic [3:0] table_codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                    4'b1111, 4'b0111, 4'b0011, 4'b0001};
    for (int i = 0; i < 8; i++) if (table_codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step(input int k);
    int v;
    bit good;
    m_cv[k] = 0; m_ce[k] = 0; m_se[k] = 0;
    if (rst) begin
      m_mode[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_bad[k] = 0;
      m_tally[k] = 0; m_count[k] = 0;
    end else if (vld) begin
      v = decode(code);
      good = (v >= 0) && ((v == (m_prev[k] + 1) % 8) || (m_hold[k] != 0 && v == m_prev[k]));
      if (v >= 0) begin m_count[k] = v; m_cv[k] = 1; end
      else m_ce[k] = 1;
      if (m_mode[k] == 0) begin
        if (v >= 0) begin m_prev[k] = v; m_run[k] = 0; m_mode[k] = 1; end
      end else if (m_mode[k] == 1) begin
        if (v < 0) m_mode[k] = 0;
        else begin
          m_run[k] = good ? m_run[k] + 1 : 0;
          m_prev[k] = v;
          if (m_run[k] >= 3) begin m_mode[k] = 2; m_bad[k] = 0; m_run[k] = 0; end
        end
      end else begin
        if (good) begin m_prev[k] = v; m_bad[k] = 0; end
        else begin
          if (v >= 0) begin m_se[k] = 1; m_prev[k] = v; end
          else m_prev[k] = (m_prev[k] + 1) % 8;
          m_bad[k]++;
          if (m_tally[k] < m_tmax[k]) m_tally[k]++;
          if (m_bad[k] >= 2) begin m_mode[k] = 0; m_bad[k] = 0; m_run[k] = 0; end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("count0", int'(cnt0), m_count[0]);
      chk("cvalid0", int'(cv0), m_cv[0]);
      chk("codeerr0", int'(ce0), m_ce[0]);
      chk("seqerr0", int'(se0), m_se[0]);
      chk("locked0", int'(lk0), int'(m_mode[0] == 2));
      chk("errcnt0", int'(ec0), m_tally[0]);
      chk("count1", int'(cnt1), m_count[1]);
      chk("cvalid1", int'(cv1), m_cv[1]);
      chk("codeerr1", int'(ce1), m_ce[1]);
      chk("seqerr1", int'(se1), m_se[1]);
      chk("locked1", int'(lk1), int'(m_mode[1] == 2));
      chk("errcnt1", int'(ec1), m_tally[1]);
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] c);
    rst = r; vld = v; code = c;
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] c);
    step(1'b0, 1'b1, c);
  endtask

  initial begin
    @(negedge clk);
    started = 1'b1;
    step(1'b1, 1'b0, 4'b0000);
    chk("lit_reset_count", int'(cnt0), 0);
    chk("lit_reset_locked", int'(lk0), 0);
    chk("lit_reset_errcnt", int'(ec0), 0);

    // Acquire lock
    send(4'b0000); chk("lit_acq_count0", int'(cnt0), 0);
    send(4'b1000); send(4'b1100);
    chk("lit_acq_unlocked", int'(lk0), 0);
    send(4'b1110);
    chk("lit_acq_count3", int'(cnt0), 3);
    chk("lit_acq_locked", int'(lk0), 1);
    chk("lit_model_locked", m_mode[0], 2);

    // Idle holds, then full wrap
    step(1'b0, 1'b0, 4'b1010);
    chk("lit_idle_hold", int'(cnt0), 3);
    chk("lit_idle_nopulse", int'(cv0), 0);
    send(4'b1111); send(4'b0111); send(4'b0011); send(4'b0001);
    chk("lit_wrap_count7", int'(cnt0), 7);
    send(4'b0000);
    chk("lit_wrap_count0", int'(cnt0), 0);
    chk("lit_wrap_noerr", int'(ec0), 0);

    // Single illegal code, flywheel carries through
    send(4'b1000); send(4'b1100); send(4'b1110);
    send(4'b1010);
    chk("lit_fly_codeerr", int'(ce0), 1);
    chk("lit_fly_hold3", int'(cnt0), 3);
    send(4'b0111);
    chk("lit_fly_count5", int'(cnt0), 5);
    chk("lit_fly_seqok", int'(se0), 0);
    chk("lit_fly_errcnt", int'(ec0), 1);
    chk("lit_fly_locked", int'(lk0), 1);

    // Sequence error with resync
    send(4'b0011); send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1100);
    send(4'b1111);
    chk("lit_seq_pulse", int'(se0), 1);
    chk("lit_seq_count4", int'(cnt0), 4);
    send(4'b0111);
    chk("lit_seq_resync", int'(se0), 0);
    chk("lit_seq_errcnt", int'(ec0), 2);
    chk("lit_seq_locked", int'(lk0), 1);

    // Two consecutive illegal codes drop lock
    send(4'b0101);
    chk("lit_drop_first", int'(lk0), 1);
    send(4'b1001);
    chk("lit_drop_unlocked", int'(lk0), 0);
    chk("lit_drop_errcnt", int'(ec0), 4);
    chk("lit_sat_errcnt1", int'(ec1), 3);

    // Relock with four correct codes
    send(4'b0000); send(4'b1000); send(4'b1100);
    chk("lit_relock_pending", int'(lk0), 0);
    send(4'b1110);
    chk("lit_relock", int'(lk0), 1);

    // Repeated code: error without hold, accepted with hold
    send(4'b1111); send(4'b0111); send(4'b0011); send(4'b0001);
    send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1100);
    chk("lit_rep_seq0", int'(se0), 1);
    chk("lit_rep_seq1", int'(se1), 0);
    chk("lit_rep_count1", int'(cnt1), 2);
    send(4'b1110);
    chk("lit_rep_errcnt0", int'(ec0), 5);

    // Wrong legal code in VERIFY restarts the match run
    step(1'b1, 1'b0, 4'b0000);
    send(4'b0000); send(4'b1000); send(4'b0011);
    chk("lit_ver_noseq", int'(se0), 0);
    send(4'b0001); send(4'b0000);
    chk("lit_ver_unlocked", int'(lk0), 0);
    send(4'b1000);
    chk("lit_ver_locked", int'(lk0), 1);

    // Reset mid-VERIFY clears everything
    step(1'b1, 1'b0, 4'b0000);
    send(4'b0000); send(4'b1000);
    step(1'b1, 1'b1, 4'b1100);
    chk("lit_rst_count", int'(cnt0), 0);
    chk("lit_rst_cv", int'(cv0), 0);
    chk("lit_rst_locked", int'(lk0), 0);
    chk("lit_rst_errcnt1", int'(ec1), 0);
    send(4'b1010);
    chk("lit_search_codeerr", int'(ce0), 1);
    chk("lit_search_noerrcnt", int'(ec0), 0);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
